// File: rtl/booth_mac_accumulator.sv
//------------------------------------------------------------------------------
// booth_mac_accumulator
// Signed multiply-accumulate over variable-length bursts. A 3-stage radix-4
// Booth 16x16 multiplier feeds a burst accumulator. Completed sums go into a
// small first-word-fall-through result FIFO with a valid/ready handshake.
// The multiplier cannot stall, so input acceptance is gated by a credit check
// that counts FIFO occupancy plus burst-closing pairs still in flight.
//
// Optional feature macro: BOOTH_MAC_SAT_EN
//   defined   : burst sums saturate to the signed ACC_W range, sticky out_sat
//   undefined : sums wrap modulo 2^ACC_W, out_sat stays 0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_radix4_mul16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);

  // Partial product for one radix-4 Booth digit {b[2i+1], b[2i], b[2i-1]}
  function automatic logic [31:0] booth_pp(input logic [15:0] mcand, input logic [2:0] trip);
    logic [31:0] ext;
    logic [31:0] pp;
    ext = {{16{mcand[15]}}, mcand};
    case (trip)
      3'b001, 3'b010: pp = ext;
      3'b011:         pp = ext << 1;
      3'b100:         pp = ~(ext << 1) + 32'd1;
      3'b101, 3'b110: pp = ~ext + 32'd1;
      default:        pp = 32'd0;
    endcase
    return pp;
  endfunction

  logic [16:0] b_ext_s;
  logic [31:0] pp_s [8];
  logic [31:0] pp_r [8];
  logic [31:0] psum_lo_s, psum_hi_s;
  logic [31:0] psum_lo_r, psum_hi_r;

  // b[-1] is an implicit 0 below the LSB
  assign b_ext_s = {b, 1'b0};

  // Recode the multiplier into eight weighted partial products
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = booth_pp(a, b_ext_s[2*i +: 3]) << (2*i);
    end
  end

  // Reduce the partial products in two halves
  always_comb begin
    psum_lo_s = pp_r[0] + pp_r[1] + pp_r[2] + pp_r[3];
    psum_hi_s = pp_r[4] + pp_r[5] + pp_r[6] + pp_r[7];
  end

  // Pipeline registers: partial products, then the two half sums
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        pp_r[i] <= 32'd0;
      end
      psum_lo_r <= 32'd0;
      psum_hi_r <= 32'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        pp_r[i] <= pp_s[i];
      end
      psum_lo_r <= psum_lo_s;
      psum_hi_r <= psum_hi_s;
    end
  end

  // Final carry-propagate add is combinational in the third stage
  assign product = psum_lo_r + psum_hi_r;

endmodule

module booth_mac_accumulator #(
  parameter int ACC_W     = 40,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [15:0]      out_cnt,
  output logic             out_sat
);

  localparam int CW = $clog2(RES_DEPTH + 3);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int EW = ACC_W + 17;

  logic                    s1_v_r, s1_last_r, s2_v_r, s2_last_r;
  logic [31:0]             product_s;
  logic signed [ACC_W-1:0] prod_ext_s, acc_r, sum_n_s;
  logic [15:0]             cnt_r, cnt_n_s;
  logic                    sat_n_s;
  logic [EW-1:0]           mem_r [RES_DEPTH];
  logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]           count_r, credit_s;
  logic                    accept_s, push_s, pop_s, in_ready_s, out_valid_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(RES_DEPTH - 1)) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  booth_radix4_mul16 u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (in_a),
    .b       (in_b),
    .product (product_s)
  );

  // A result slot is reserved for every burst-closing pair in flight;
  // a same-cycle pop is deliberately not credited.
  assign credit_s    = count_r + CW'(s1_v_r & s1_last_r) + CW'(s2_v_r & s2_last_r);
  assign in_ready_s  = (credit_s < CW'(RES_DEPTH));
  assign accept_s    = in_valid & in_ready_s;
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign push_s      = s2_v_r & s2_last_r;
  assign pop_s       = out_valid_s & out_ready;

  assign prod_ext_s  = ACC_W'($signed(product_s));
  assign cnt_n_s     = cnt_r + 16'd1;

  // Sideband {valid, last} travels alongside the two multiplier registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_r    <= 1'b0;
      s1_last_r <= 1'b0;
      s2_v_r    <= 1'b0;
      s2_last_r <= 1'b0;
    end else begin
      s1_v_r    <= accept_s;
      s1_last_r <= in_last;
      s2_v_r    <= s1_v_r;
      s2_last_r <= s1_last_r;
    end
  end

`ifdef BOOTH_MAC_SAT_EN
  logic                  sat_r;
  logic signed [ACC_W:0] wide_s;

  // Add with one guard bit and clamp on signed overflow
  always_comb begin
    wide_s  = {acc_r[ACC_W-1], acc_r} + {prod_ext_s[ACC_W-1], prod_ext_s};
    sum_n_s = wide_s[ACC_W-1:0];
    sat_n_s = sat_r;
    if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
      sat_n_s = 1'b1;
      if (wide_s[ACC_W]) begin
        sum_n_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_n_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sum_n_s = wide_s[ACC_W-1:0];
    end
  end

  // Sticky per-burst saturation flag, cleared when the burst closes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if (s2_v_r) begin
      sat_r <= s2_last_r ? 1'b0 : sat_n_s;
    end
  end
`else
  // Wrap-around accumulation; the stored flag is always 0
  always_comb begin
    sum_n_s = acc_r + prod_ext_s;
    sat_n_s = 1'b0;
  end
`endif

  // Burst accumulator: clears after the closing pair is pushed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= 16'd0;
    end else if (s2_v_r) begin
      if (s2_last_r) begin
        acc_r <= {ACC_W{1'b0}};
        cnt_r <= 16'd0;
      end else begin
        acc_r <= sum_n_s;
        cnt_r <= cnt_n_s;
      end
    end
  end

  // Result storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {sum_n_s, cnt_n_s, sat_n_s};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_sum   = mem_r[rd_ptr_r][EW-1:17];
  assign out_cnt   = mem_r[rd_ptr_r][16:1];
  assign out_sat   = mem_r[rd_ptr_r][0];

endmodule

// File: tb/tb_booth_mac_accumulator.sv
//------------------------------------------------------------------------------
// Self-checking bench for booth_mac_accumulator (ACC_W=32, RES_DEPTH=4).
// Directed vector table, hand-written timing/back-pressure/reset sequences,
// randomized traffic against an arithmetic burst model, and a long burst.
// Expected saturation results follow BOOTH_MAC_SAT_EN when defined.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_booth_mac_accumulator;

  localparam int TB_ACC_W = 32;
  localparam int TB_DEPTH = 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_a;
  logic [15:0]         in_b;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [TB_ACC_W-1:0] out_sum;
  logic [15:0]         out_cnt;
  logic                out_sat;

  booth_mac_accumulator #(.ACC_W(TB_ACC_W), .RES_DEPTH(TB_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint sum; int cnt; bit sat; } res_t;
  typedef struct { int a; int b; bit last; longint esum; int ecnt; bit esat; } vec_t;

`ifdef BOOTH_MAC_SAT_EN
  localparam longint ACC_MAX  = 64'sd2147483647;
  localparam longint ACC_MIN  = -64'sd2147483648;
  localparam longint POS3     = 64'sd2147483647;
  localparam longint NEG3     = -64'sd2147483648;
  localparam longint CONT     = 64'sd2147483646;
  localparam bit     SATF     = 1'b1;
`else
  localparam longint POS3     = -64'sd1073741824;
  localparam longint NEG3     = 64'sd1073840128;
  localparam longint CONT     = 64'sd2147483647;
  localparam bit     SATF     = 1'b0;

  function automatic longint wrapw(input longint x);
    logic signed [TB_ACC_W-1:0] t;
    t = x[TB_ACC_W-1:0];
    return longint'(t);
  endfunction
`endif

  int     n_cmp = 0;
  int     n_bad = 0;
  res_t   exp_q[$];
  vec_t   tbl[19];
  bit     model_on = 1'b0;
  longint m_acc = 0, m_p, m_s;
  int     m_cnt = 0;
  bit     m_sat = 1'b0;
  int     occ = 0, l1 = 0, l2 = 0;
  int     pops = 0;
  longint last_sum = 0;
  int     last_cnt = 0;
  bit     mon_pop, mon_acc;
  res_t   mon_e, mon_r;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: credit/valid timing model, scoreboard pops, burst arithmetic model
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_sat = 1'b0;
      occ = 0; l1 = 0; l2 = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'((occ + l1 + l2) < TB_DEPTH));
      check("out_valid", longint'(out_valid), longint'(occ > 0));
      mon_pop = out_valid && out_ready;
      if (mon_pop) begin
        pops++;
        last_sum = longint'($signed(out_sum));
        last_cnt = int'(out_cnt);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got sum %0d cnt %0d, required no result", last_sum, last_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_sum", last_sum, mon_e.sum);
          check("out_cnt", longint'(out_cnt), longint'(mon_e.cnt));
          check("out_sat", longint'(out_sat), longint'(mon_e.sat));
        end
      end
      mon_acc = in_valid && in_ready;
      if (mon_acc && model_on) begin
        m_p = longint'($signed(in_a)) * longint'($signed(in_b));
        m_s = m_acc + m_p;
`ifdef BOOTH_MAC_SAT_EN
        if (m_s > ACC_MAX) begin
          m_s = ACC_MAX; m_sat = 1'b1;
        end else if (m_s < ACC_MIN) begin
          m_s = ACC_MIN; m_sat = 1'b1;
        end
`else
        m_s = wrapw(m_s);
`endif
        m_cnt = (m_cnt + 1) % 65536;
        if (in_last) begin
          mon_r.sum = m_s; mon_r.cnt = m_cnt; mon_r.sat = m_sat;
          exp_q.push_back(mon_r);
          m_acc = 0; m_cnt = 0; m_sat = 1'b0;
        end else begin
          m_acc = m_s;
        end
      end
      occ = occ + l2 - (mon_pop ? 1 : 0);
      l2  = l1;
      l1  = (mon_acc && in_last) ? 1 : 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int a, input int b, input bit last);
    bit done = 1'b0;
    in_a = 16'(a); in_b = 16'(b); in_last = last; in_valid = 1'b1;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready stuck 0, required acceptance within 300 cycles");
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    @(posedge clk); #1;
    check("drain", longint'(done), 64'sd1);
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0) return -32768;
    else if (r == 1) return 32767;
    else return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int accepted;
    int p0;
    res_t r;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_last = 1'b0; out_ready = 1'b1;

    tbl[0]  = '{3, 4, 1'b0, 64'sd0, 0, 1'b0};
    tbl[1]  = '{-5, 6, 1'b0, 64'sd0, 0, 1'b0};
    tbl[2]  = '{7, -8, 1'b1, -64'sd74, 3, 1'b0};
    tbl[3]  = '{-32768, -32768, 1'b1, 64'sd1073741824, 1, 1'b0};
    tbl[4]  = '{-32768, 32767, 1'b1, -64'sd1073709056, 1, 1'b0};
    tbl[5]  = '{-32768, -32768, 1'b0, 64'sd0, 0, 1'b0};
    tbl[6]  = '{-32768, -32768, 1'b0, 64'sd0, 0, 1'b0};
    tbl[7]  = '{-32768, -32768, 1'b1, POS3, 3, SATF};
    tbl[8]  = '{32767, 32767, 1'b1, 64'sd1073676289, 1, 1'b0};
    tbl[9]  = '{-1, 1, 1'b1, -64'sd1, 1, 1'b0};
    tbl[10] = '{0, -32768, 1'b1, 64'sd0, 1, 1'b0};
    tbl[11] = '{255, -256, 1'b0, 64'sd0, 0, 1'b0};
    tbl[12] = '{-1000, 1000, 1'b1, -64'sd1065280, 2, 1'b0};
    tbl[13] = '{-32768, 32767, 1'b0, 64'sd0, 0, 1'b0};
    tbl[14] = '{-32768, 32767, 1'b0, 64'sd0, 0, 1'b0};
    tbl[15] = '{-32768, 32767, 1'b1, NEG3, 3, SATF};
    tbl[16] = '{-32768, -32768, 1'b0, 64'sd0, 0, 1'b0};
    tbl[17] = '{-32768, -32768, 1'b0, 64'sd0, 0, 1'b0};
    tbl[18] = '{1, -1, 1'b1, CONT, 3, SATF};

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 64'sd1);
    check("rst_out_valid", longint'(out_valid), 64'sd0);
    check("rst_out_sum", longint'(out_sum), 64'sd0);
    check("rst_out_cnt", longint'(out_cnt), 64'sd0);
    check("rst_out_sat", longint'(out_sat), 64'sd0);
    @(posedge clk); #1;

    // Latency: pairs in cycles 0..2, result visible only in cycle 5
    r.sum = -64'sd74; r.cnt = 3; r.sat = 1'b0;
    exp_q.push_back(r);
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 3);
      in_a = (k == 0) ? 16'sd3 : (k == 1) ? -16'sd5 : 16'sd7;
      in_b = (k == 0) ? 16'sd4 : (k == 1) ? 16'sd6 : -16'sd8;
      in_last = (k == 2);
      @(negedge clk);
      check("lat_out_valid", longint'(out_valid), longint'(k == 5));
      @(posedge clk); #1;
    end

    // Directed vector table, applied back to back
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].last) begin
        r.sum = tbl[i].esum; r.cnt = tbl[i].ecnt; r.sat = tbl[i].esat;
        exp_q.push_back(r);
      end
      send(tbl[i].a, tbl[i].b, tbl[i].last);
    end
    wait_drain();

    // Back-pressure: single-pair bursts with the consumer stalled
    do_reset();
    model_on = 1'b1;
    out_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 14; k++) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_a = 16'(accepted + 1); in_b = 16'(accepted + 1);
      @(negedge clk);
      if (k == 4 || k == 13) check("bp_in_ready_low", longint'(in_ready), 64'sd0);
      if (in_ready) accepted++;
      @(posedge clk); #1;
    end
    check("bp_accepted", longint'(accepted), 64'sd4);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && accepted < 6; k++) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_a = 16'(accepted + 1); in_b = 16'(accepted + 1);
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_recovered", longint'(accepted), 64'sd6);
    wait_drain();

    // Reset in the middle of a burst drops the partial sum
    send(100, 100, 1'b0);
    send(100, 100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = pops;
    send(1, 1, 1'b1);
    wait_drain();
    check("mid_rst_pops", longint'(pops - p0), 64'sd1);
    check("mid_rst_sum", last_sum, 64'sd1);
    check("mid_rst_cnt", longint'(last_cnt), 64'sd1);

    // Randomized traffic against the burst model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 16'(pick());
      in_b      = 16'(pick());
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(0, 0, 1'b1);
    wait_drain();

    // Long burst: pair count wraps modulo 2^16
    for (int k = 0; k < 65536; k++) send(1, 1, 1'b0);
    send(1, 1, 1'b1);
    wait_drain();
    check("long_cnt", longint'(last_cnt), 64'sd1);
    check("long_sum", last_sum, 64'sd65537);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
